// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | regfile_wb_arbiter: ALU/LSU writeback arbiter, registered RF write port,   |
// | busy-bit scoreboard. REGFILE_WB_RR_EN selects round-robin arbitration.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module regfile_wb_arbiter #(
   parameter int XLEN = 32,
   parameter int AW   = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              issue_valid,
   input  logic [AW-1:0]     issue_rd,
   input  logic [AW-1:0]     issue_rs1,
   input  logic [AW-1:0]     issue_rs2,
   output logic              issue_stall,
   input  logic              alu_valid,
   input  logic [AW-1:0]     alu_rd,
   input  logic [XLEN-1:0]   alu_data,
   output logic              alu_ready,
   input  logic              lsu_valid,
   input  logic [AW-1:0]     lsu_rd,
   input  logic [XLEN-1:0]   lsu_data,
   output logic              lsu_ready,
   output logic              rf_w_en,
   output logic [AW-1:0]     rf_rd,
   output logic [XLEN-1:0]   rf_w_data,
   output logic [2**AW-1:0]  busy_vec
);
   localparam int NREG = 2**AW;

   logic [NREG-1:0] busy_q, busy_d;
   logic            rf_w_en_q, rf_w_en_d;
   logic [AW-1:0]   rf_rd_q, rf_rd_d;
   logic [XLEN-1:0] rf_w_data_q, rf_w_data_d;
   logic            grant_alu, grant_lsu;
   logic            issue_accept;

`ifdef REGFILE_WB_RR_EN
   // Pointer records the side that won the most recent tie.
   typedef enum logic {PTR_ALU = 1'b0, PTR_LSU = 1'b1} ptr_e;
   ptr_e ptr_q, ptr_d;

   always_comb begin
      grant_alu = 1'b0;
      grant_lsu = 1'b0;
      ptr_d     = ptr_q;
      if (alu_valid && lsu_valid) begin
         if (ptr_q == PTR_ALU) begin
            grant_lsu = 1'b1;
            ptr_d     = PTR_LSU;
         end else begin
            grant_alu = 1'b1;
            ptr_d     = PTR_ALU;
         end
      end else begin
         grant_alu = alu_valid;
         grant_lsu = lsu_valid;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= PTR_ALU;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`else
   always_comb begin
      grant_lsu = lsu_valid;
      grant_alu = alu_valid & ~lsu_valid;
   end
`endif

   assign alu_ready = grant_alu;
   assign lsu_ready = grant_lsu;

   // No bypass: a register stays stalled through its rf_w_en cycle.
   assign issue_stall  = issue_valid &
                         (busy_q[issue_rs1] | busy_q[issue_rs2] | busy_q[issue_rd]);
   assign issue_accept = issue_valid & ~issue_stall;

   always_comb begin
      rf_w_en_d   = 1'b0;
      rf_rd_d     = rf_rd_q;
      rf_w_data_d = rf_w_data_q;
      if (grant_lsu) begin
         rf_w_en_d   = |lsu_rd;
         rf_rd_d     = lsu_rd;
         rf_w_data_d = lsu_data;
      end else if (grant_alu) begin
         rf_w_en_d   = |alu_rd;
         rf_rd_d     = alu_rd;
         rf_w_data_d = alu_data;
      end
   end

   // Set is applied after clear so a new producer keeps the register busy.
   always_comb begin
      busy_d = busy_q;
      if (rf_w_en_q) begin
         busy_d[rf_rd_q] = 1'b0;
      end
      if (issue_accept && (issue_rd != '0)) begin
         busy_d[issue_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q      <= '0;
         rf_w_en_q   <= 1'b0;
         rf_rd_q     <= '0;
         rf_w_data_q <= '0;
      end else begin
         busy_q      <= busy_d;
         rf_w_en_q   <= rf_w_en_d;
         rf_rd_q     <= rf_rd_d;
         rf_w_data_q <= rf_w_data_d;
      end
   end

   assign rf_w_en   = rf_w_en_q;
   assign rf_rd     = rf_rd_q;
   assign rf_w_data = rf_w_data_q;
   assign busy_vec  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_regfile_wb_arbiter: directed plus randomized bench with a behavioural   |
// | model of arbitration, write-port timing and the scoreboard.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_regfile_wb_arbiter;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        issue_valid;
   logic [4:0]  issue_rd, issue_rs1, issue_rs2;
   logic        issue_stall;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        alu_ready;
   logic        lsu_valid;
   logic [4:0]  lsu_rd;
   logic [31:0] lsu_data;
   logic        lsu_ready;
   logic        rf_w_en;
   logic [4:0]  rf_rd;
   logic [31:0] rf_w_data;
   logic [31:0] busy_vec;

   regfile_wb_arbiter #(.XLEN(32), .AW(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rs1(issue_rs1),
      .issue_rs2(issue_rs2), .issue_stall(issue_stall),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
      .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
      .rf_w_en(rf_w_en), .rf_rd(rf_rd), .rf_w_data(rf_w_data), .busy_vec(busy_vec)
   );

   always #5 clk = ~clk;

   // Register file fed by the write port, used for read-back checks.
   logic [31:0] tb_rf [32];
   always @(posedge clk) begin
      if (rf_w_en) tb_rf[rf_rd] <= rf_w_data;
   end

   int n_pass = 0;
   int n_total = 0;

   // Behavioural model state
   logic [31:0] m_busy;
   logic        m_wen;
   logic [4:0]  m_rd;
   logic [31:0] m_data;
   logic        m_last_lsu;
   logic        exp_alu, exp_lsu, exp_stall;
   logic        alu_taken, lsu_taken;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      m_busy = '0; m_wen = 1'b0; m_rd = '0; m_data = '0; m_last_lsu = 1'b0;
      alu_taken = 1'b0; lsu_taken = 1'b0;
   endtask

   task automatic step_check();
      #4;
      if (alu_valid && lsu_valid) begin
`ifdef REGFILE_WB_RR_EN
         exp_lsu = !m_last_lsu;
`else
         exp_lsu = 1'b1;
`endif
         exp_alu = !exp_lsu;
      end else begin
         exp_lsu = lsu_valid;
         exp_alu = alu_valid;
      end
      exp_stall = issue_valid && (m_busy[issue_rs1] || m_busy[issue_rs2] || m_busy[issue_rd]);
      chk("busy_vec", busy_vec, m_busy);
      chk("rf_w_en", 32'(rf_w_en), 32'(m_wen));
      if (m_wen) begin
         chk("rf_rd", 32'(rf_rd), 32'(m_rd));
         chk("rf_w_data", rf_w_data, m_data);
      end
      chk("alu_ready", 32'(alu_ready), 32'(exp_alu));
      chk("lsu_ready", 32'(lsu_ready), 32'(exp_lsu));
      chk("issue_stall", 32'(issue_stall), 32'(exp_stall));
   endtask

   task automatic step_advance();
      logic [31:0] nb;
      nb = m_busy;
      if (m_wen) nb[m_rd] = 1'b0;
      if (issue_valid && !exp_stall && issue_rd != 5'd0) nb[issue_rd] = 1'b1;
      if (exp_lsu) begin
         m_wen = (lsu_rd != 5'd0); m_rd = lsu_rd; m_data = lsu_data;
      end else if (exp_alu) begin
         m_wen = (alu_rd != 5'd0); m_rd = alu_rd; m_data = alu_data;
      end else begin
         m_wen = 1'b0;
      end
      if (alu_valid && lsu_valid) m_last_lsu = exp_lsu;
      m_busy = nb;
      alu_taken = exp_alu;
      lsu_taken = exp_lsu;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [4:0] pick_rd();
      logic [4:0] r;
      r = 5'($urandom_range(1, 7));
      if ($urandom_range(0, 1) == 1 && m_busy[r]) return r;
      return 5'($urandom_range(0, 7));
   endfunction

   initial begin
      rst_n = 1'b0;
      issue_valid = 0; issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
      alu_valid = 0; alu_rd = 0; alu_data = 0;
      lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Idle after reset; an all-zero issue must never stall
      for (int i = 0; i < 5; i++) begin
         issue_valid = 1'b1;
         step_check();
         chk("idle_busy", busy_vec, 32'h0);
         chk("idle_wen", 32'(rf_w_en), 32'h0);
         chk("idle_stall", 32'(issue_stall), 32'h0);
         if (i == 0) begin
            chk("reset_rf_rd", 32'(rf_rd), 32'h0);
            chk("reset_rf_w_data", rf_w_data, 32'h0);
         end
         step_advance();
      end

      // RAW on x5 resolved by an ALU writeback
      issue_rd = 5'd5;
      step_check();
      chk("raw_first_issue_stall", 32'(issue_stall), 32'h0);
      step_advance();
      issue_rd = 5'd0; issue_rs1 = 5'd5;
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
      step_check();
      chk("raw_stall_N", 32'(issue_stall), 32'h1);
      chk("raw_alu_ready_N", 32'(alu_ready), 32'h1);
      chk("raw_busy_N", busy_vec, 32'h0000_0020);
      step_advance();
      alu_valid = 1'b0;
      step_check();
      chk("raw_stall_N1", 32'(issue_stall), 32'h1);
      chk("raw_wen_N1", 32'(rf_w_en), 32'h1);
      chk("raw_rd_N1", 32'(rf_rd), 32'h5);
      chk("raw_data_N1", rf_w_data, 32'hDEADBEEF);
      step_advance();
      step_check();
      chk("raw_stall_N2", 32'(issue_stall), 32'h0);
      chk("raw_read_x5", tb_rf[5], 32'hDEADBEEF);
      step_advance();
      issue_valid = 1'b0; issue_rs1 = 5'd0;

      // Simultaneous ALU x3 / LSU x4
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h3333_0003;
      lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h4444_0004;
`ifdef REGFILE_WB_RR_EN
      for (int i = 0; i < 4; i++) begin
         step_check();
         chk("rr_lsu_ready", 32'(lsu_ready), (i % 2 == 0) ? 32'h1 : 32'h0);
         chk("rr_alu_ready", 32'(alu_ready), (i % 2 == 1) ? 32'h1 : 32'h0);
         step_advance();
      end
      alu_valid = 1'b0; lsu_valid = 1'b0;
      step_check();
      step_advance();
`else
      step_check();
      chk("tie_lsu_ready", 32'(lsu_ready), 32'h1);
      chk("tie_alu_ready", 32'(alu_ready), 32'h0);
      step_advance();
      lsu_valid = 1'b0;
      step_check();
      chk("tie_alu_ready2", 32'(alu_ready), 32'h1);
      chk("tie_wen_x4", 32'(rf_w_en), 32'h1);
      chk("tie_rd_x4", 32'(rf_rd), 32'h4);
      step_advance();
      alu_valid = 1'b0;
      step_check();
      chk("tie_wen_x3", 32'(rf_w_en), 32'h1);
      chk("tie_rd_x3", 32'(rf_rd), 32'h3);
      step_advance();
`endif

      // LSU writeback to x0
      lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h1;
      step_check();
      chk("x0_lsu_ready", 32'(lsu_ready), 32'h1);
      step_advance();
      lsu_valid = 1'b0;
      step_check();
      chk("x0_wen", 32'(rf_w_en), 32'h0);
      chk("x0_busy0", 32'(busy_vec[0]), 32'h0);
      step_advance();

      // Same-edge clear and set of x7
      alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h0000_0077;
      step_check();
      chk("x7_alu_ready", 32'(alu_ready), 32'h1);
      step_advance();
      alu_valid = 1'b0;
      issue_valid = 1'b1; issue_rd = 5'd7;
      step_check();
      chk("x7_wen", 32'(rf_w_en), 32'h1);
      chk("x7_rd", 32'(rf_rd), 32'h7);
      chk("x7_issue_stall", 32'(issue_stall), 32'h0);
      step_advance();
      issue_valid = 1'b0;
      step_check();
      chk("x7_busy_after", 32'(busy_vec[7]), 32'h1);
      step_advance();

      // Asynchronous reset with busy x5/x7 and a write in flight
      issue_valid = 1'b1; issue_rd = 5'd5;
      alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h0000_0022;
      step_check();
      step_advance();
      issue_valid = 1'b0; alu_valid = 1'b0;
      step_check();
      chk("pre_rst_busy", busy_vec, 32'h0000_00A0);
      chk("pre_rst_wen", 32'(rf_w_en), 32'h1);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_busy", busy_vec, 32'h0);
      chk("async_rst_wen", 32'(rf_w_en), 32'h0);
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      step_check();
      chk("post_rst_rf_rd", 32'(rf_rd), 32'h0);
      step_advance();

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         if (alu_taken) alu_valid = 1'b0;
         if (lsu_taken) lsu_valid = 1'b0;
         if (!alu_valid && $urandom_range(0, 2) == 0) begin
            alu_valid = 1'b1; alu_rd = pick_rd(); alu_data = $urandom;
         end
         if (!lsu_valid && $urandom_range(0, 2) == 0) begin
            lsu_valid = 1'b1; lsu_rd = pick_rd(); lsu_data = $urandom;
         end
         issue_valid = 1'($urandom_range(0, 1));
         issue_rd    = 5'($urandom_range(0, 7));
         issue_rs1   = 5'($urandom_range(0, 7));
         issue_rs2   = 5'($urandom_range(0, 7));
         step_check();
         step_advance();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Owns the single write port of the 32x32 integer register file, which has synchronous writes, asynchronous reads and x0 hardwired to zero.
- Arbitrates two writeback requesters onto that port: the ALU path and the load/store unit (LSU).
- Keeps a busy-bit scoreboard of destination registers with writes still outstanding, and raises a stall to decode on RAW/WAW hazards.
- Sits between the execute/memory stages and the register file.

Parameters:
- XLEN, 32, data width of register values.
- AW, 5, register index width; the scoreboard holds 2**AW entries.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. Asynchronous, active-low.
- issue_valid  in  1  decode wants to issue an instruction this cycle.
- issue_rd  in  AW  destination register of the issuing instruction; 0 means no write.
- issue_rs1  in  AW  source register 1 of the issuing instruction.
- issue_rs2  in  AW  source register 2 of the issuing instruction.
- issue_stall  out  1  decode must hold; the instruction is not accepted.
- alu_valid  in  1  ALU writeback request.
- alu_rd  in  AW  ALU writeback destination.
- alu_data  in  XLEN  ALU writeback value.
- alu_ready  out  1  ALU request granted this cycle.
- lsu_valid  in  1  LSU writeback request.
- lsu_rd  in  AW  LSU writeback destination.
- lsu_data  in  XLEN  LSU writeback value.
- lsu_ready  out  1  LSU request granted this cycle.
- rf_w_en  out  1  register file write enable.
- rf_rd  out  AW  register file write index.
- rf_w_data  out  XLEN  register file write data.
- busy_vec  out  2**AW  scoreboard contents, for debug and forwarding.

Behaviour:
- Reset values: busy_vec=0, rf_w_en=0, rf_rd=0, rf_w_data=0, round-robin pointer=ALU. Reset asserted mid-operation drops any in-flight write and clears every busy bit at once.
- Handshake:
  - A request transfers on a cycle where valid & ready.
  - A requester holds valid, rd and data stable until it sees ready.
  - ready is combinational from the valid inputs and the arbitration state.
  - At most one ready per cycle.
- Arbitration, default fixed priority:
  - LSU wins over ALU.
  - If only one side is valid, that side is granted.
  - No grant when neither side is valid.
- Write-port registration:
  - A grant in cycle N drives rf_w_en=1 with rf_rd and rf_w_data in cycle N+1.
  - The register file captures the value at the end of N+1; async reads return it from N+2.
  - Total latency from grant to visible value: 2 cycles.
  - With no grant in cycle N, rf_w_en=0 in N+1; rf_rd and rf_w_data hold their previous values.
- x0 handling:
  - A granted request with rd=0 is still consumed (ready=1) but produces rf_w_en=0.
  - busy bit 0 is never set and always reads 0.
- Issue acceptance:
  - issue_stall = issue_valid & (busy[rs1] | busy[rs2] | busy[rd]).
  - Accepted issue: issue_valid & ~issue_stall.
- Scoreboard set: an accepted issue with issue_rd!=0 sets busy[issue_rd] at the next edge.
- Scoreboard clear: busy[rf_rd] clears at the edge ending a cycle in which rf_w_en=1.
- Set and clear of the same index on the same edge: set wins, so the register stays busy for the new producer.
- Stall persists through the rf_w_en cycle. The earliest cycle a dependent instruction can be accepted is N+2 after the grant.
- No bypass from the write port to issue_stall.
- A writeback to a register that is not busy is legal: it writes the file and leaves busy unchanged at 0.

Optional Feature:
- Macro: REGFILE_WB_RR_EN.
- Defined: arbitration is round-robin.
  - When both requesters are valid, the side opposite the last granted side wins.
  - The pointer updates only on a grant taken while both were valid.
  - The pointer resets to ALU, so the first tie goes to LSU.
- Undefined: fixed LSU priority, no pointer register.

Test Plan:
- Reset, then idle 5 cycles -> busy_vec=0, rf_w_en=0, issue_stall=0 for any issue with rd=rs1=rs2=0.
- Issue rd=5, then next cycle issue rs1=5 -> second issue stalls. ALU writes rd=5 data=0xDEADBEEF granted in cycle N -> rf_w_en=1, rf_rd=5 in N+1; stall drops in N+2; the read of x5 returns 0xDEADBEEF.
- ALU rd=3 and LSU rd=4 both valid in the same cycle:
  - Fixed priority: lsu_ready=1 first, then alu_ready=1 the next cycle; rf writes x4 then x3 on consecutive cycles.
  - REGFILE_WB_RR_EN, 4 back-to-back ties: grants go LSU, ALU, LSU, ALU.
- LSU writeback rd=0 data=0x1 -> lsu_ready=1, rf_w_en stays 0, busy_vec[0]=0.
- Same-cycle clear of x7 (rf_w_en=1, rf_rd=7) and accepted issue rd=7 -> busy[7]=1 after the edge.
- rst_n pulsed low mid-cycle while busy_vec=0x000000A0 and a grant is pending -> busy_vec=0 and rf_w_en=0 immediately, without waiting for a clock edge.
